slot_deserializer: RTL

SLOT_DESERIALIZER -- requirements
Module: slot_deserializer

---
 rtl/slot_deserializer.sv | 113 +++++++++++
 1 files changed

// File: rtl/slot_deserializer.sv
// slot_deserializer: assembles four W-bit slot words (slot 0..3, in_last on
// slot 3) into one 4*W frame {w3,w2,w1,w0}, with sequence checking.
// Ports: ph1/reset_n clock and async active-low reset; in_valid/in_ready/
// in_slot/in_last/in_data slot-word input; out_valid/out_ready/out_data frame
// output; sync_err one-cycle violation pulse; frame_cnt delivered frames
// (wraps); err_cnt saturating violation count.
module slot_deserializer #(
    parameter int W = 8
) (
    input  logic           ph1,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_slot,
    input  logic           in_last,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W-1:0] out_data,
    output logic           sync_err,
    output logic [7:0]     frame_cnt,
    output logic [3:0]     err_cnt
);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]   state;
    logic [1:0]   exp;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic [W-1:0] w2;

    logic       accept;
    logic       take;
    logic       beat_start;
    logic       beat_ok;
    logic       beat_end;
    logic [1:0] cur;

    assign out_valid = (state == HOLD);
    assign in_ready  = !(out_valid && !out_ready);
    assign take      = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    assign beat_start = accept && (in_slot == 2'd0) && !in_last;
    assign beat_ok    = accept && (in_slot == exp) && (exp != 2'd3)
                        && !in_last;
    assign beat_end   = accept && (in_slot == 2'd3) && (exp == 2'd3)
                        && in_last;

    // A frame consumed this cycle frees the FSM, so a beat arriving on the
    // same edge is judged by the HUNT rules.
    assign cur = take ? HUNT : state;

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            exp       <= 2'd0;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            out_data  <= '0;
            sync_err  <= 1'b0;
            frame_cnt <= 8'd0;
            err_cnt   <= 4'd0;
        end else begin
            sync_err <= 1'b0;
            if (take) begin
                frame_cnt <= frame_cnt + 8'd1;
                state     <= HUNT;
            end
            if (cur == HUNT) begin
                if (beat_start) begin
                    w0    <= in_data;
                    exp   <= 2'd1;
                    state <= COLLECT;
                end
            end else if (cur == COLLECT && accept) begin
                unique case (1'b1)
                    beat_ok: begin
                        case (exp)
                            2'd1:    w1 <= in_data;
                            2'd2:    w2 <= in_data;
                            default: ;
                        endcase
                        exp <= exp + 2'd1;
                    end
                    beat_end: begin
                        out_data <= {in_data, w2, w1, w0};
                        exp      <= 2'd0;
                        state    <= HOLD;
                    end
                    default: begin
                        sync_err <= 1'b1;
                        if (err_cnt != 4'hf)
                            err_cnt <= err_cnt + 4'd1;
                        // A fresh slot 0 resynchronises immediately.
                        if (beat_start) begin
                            w0  <= in_data;
                            exp <= 2'd1;
                        end else begin
                            exp   <= 2'd0;
                            state <= HUNT;
                        end
                    end
                endcase
            end
        end
    end

endmodule
